// File: rtl/keypad_scanner_pkg.sv
// Shared keypad scanner types and constants.
// Matrix geometry, debounce states and snapshot helpers.
package keypad_scanner_pkg;

  localparam int KP_ROWS   = 4;
  localparam int KP_COLS   = 4;
  localparam int KP_CODE_W = 4;
  localparam int KP_KEYS   = KP_ROWS * KP_COLS;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_CONFIRM = 2'd1,
    DB_ACCEPT  = 2'd2,
    DB_HELD    = 2'd3
  } db_state_e;

  function automatic logic [4:0] kp_popcount(
    input logic [KP_KEYS-1:0] v
  );
    kp_popcount = 5'($countones(v));
  endfunction

  // Index of the highest set bit; only meaningful
  // when exactly one bit is set.
  function automatic logic [KP_CODE_W-1:0] kp_encode(
    input logic [KP_KEYS-1:0] v
  );
    logic [KP_CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      if (v[4'(i)]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Per-bit two-stage synchronizer for the row lines.
// Resets to all ones so idle (pulled-up) rows read as released.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two flops in series; first may go metastable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and
// valid/ready output of one key code per press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 20000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KP_ROWS-1:0]   row_in,
  output logic [KP_COLS-1:0]   col_sel,
  output logic [KP_CODE_W-1:0] key_code,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic                 key_held,
  output logic                 overrun
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE_SCANS - 1);

  logic [KP_ROWS-1:0]   rows_raw;
  logic [KP_ROWS-1:0]   rows;
  logic [DIV_W-1:0]     div_cnt;
  logic [1:0]           col_idx;
  logic                 col_last;
  logic [KP_KEYS-1:0]   snapshot;
  logic                 scan_done;
  logic [4:0]           pop;
  logic [KP_CODE_W-1:0] code;
  logic                 is_none;
  logic                 is_one;
  db_state_e            state;
  db_state_e            state_n;
  logic [KP_CODE_W-1:0] cand;
  logic [KP_CODE_W-1:0] cand_n;
  logic [CNT_W-1:0]     db_cnt;
  logic [CNT_W-1:0]     db_cnt_n;
  logic                 report;
  logic                 hs;

  sync_2ff #(
    .W (KP_ROWS)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_in),
    .q     (rows_raw)
  );

  assign rows     = ~rows_raw;
  assign col_last = (div_cnt == DIV_LAST);
  assign col_sel  = ~(4'b0001 << col_idx);

  // Column dwell counter and column rotator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= '0;
    end else if (col_last) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Capture rows of the active column on its last
  // cycle; bit index is {row, col} = key code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snapshot  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= col_last && (col_idx == 2'd3);
      if (col_last) begin
        for (int r = 0; r < KP_ROWS; r++) begin
          snapshot[{2'(r), col_idx}] <= rows[2'(r)];
        end
      end
    end
  end

  // Classify the completed scan.
  always_comb begin
    pop     = kp_popcount(snapshot);
    code    = kp_encode(snapshot);
    is_none = (pop == 5'd0);
    is_one  = (pop == 5'd1);
  end

  // Debounce state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= DB_IDLE;
      cand   <= '0;
      db_cnt <= '0;
    end else begin
      state  <= state_n;
      cand   <= cand_n;
      db_cnt <= db_cnt_n;
    end
  end

  // Debounce next-state: press and release each
  // need DEBOUNCE_SCANS matching scans.
  always_comb begin
    state_n  = state;
    cand_n   = cand;
    db_cnt_n = db_cnt;
    unique case (state)
      DB_IDLE: begin
        if (scan_done && is_one) begin
          cand_n   = code;
          db_cnt_n = CNT_W'(1);
          if (DEBOUNCE_SCANS == 1)
            state_n = DB_ACCEPT;
          else
            state_n = DB_CONFIRM;
        end
      end
      DB_CONFIRM: begin
        if (scan_done) begin
          if (is_one && (code == cand)) begin
            db_cnt_n = db_cnt + CNT_W'(1);
            if (db_cnt == DB_LAST)
              state_n = DB_ACCEPT;
          end else begin
            db_cnt_n = '0;
            state_n  = DB_IDLE;
          end
        end
      end
      DB_ACCEPT: begin
        db_cnt_n = '0;
        state_n  = DB_HELD;
      end
      DB_HELD: begin
        if (scan_done) begin
          if (!is_none) begin
            db_cnt_n = '0;
          end else if (db_cnt == DB_LAST) begin
            db_cnt_n = '0;
            state_n  = DB_IDLE;
          end else begin
            db_cnt_n = db_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        db_cnt_n = '0;
        state_n  = DB_IDLE;
      end
    endcase
  end

  assign key_held = (state == DB_HELD);
  assign report   = (state == DB_ACCEPT);
  assign hs       = key_valid && key_ready;

  // Output holding register; a report that finds
  // the slot still full is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (report && (!key_valid || hs)) begin
      key_code  <= cand;
      key_valid <= 1'b1;
      if (hs) overrun <= 1'b0;
    end else if (report) begin
      overrun <= 1'b1;
    end else if (hs) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule
